// File: rtl/regbank_demux16.sv
// Eight-entry register bank with a 1:8 byte-masked write demux and a sequential clear sweep.
// Writes land on Q one cycle after acceptance; wr_ready drops for the whole 8-cycle sweep (no queuing).
module regbank_demux16 #(
  parameter int WIDTH   = 16,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       wr_be,
  output logic             wr_ack,
  input  logic             clr_req,
  output logic             busy,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic [WIDTH-1:0] Q4,
  output logic [WIDTH-1:0] Q5,
  output logic [WIDTH-1:0] Q6,
  output logic [WIDTH-1:0] Q7
);

  localparam int HALF = WIDTH / 2;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_nxt;
  logic [2:0]       cnt, cnt_nxt;
  logic [WIDTH-1:0] regs [8];
  logic             wr_fire;

  assign wr_ready = (state == IDLE);
  assign busy     = (state == CLEAR);
  assign wr_fire  = wr_valid & wr_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = 3'd0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd7) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      wr_ack <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      wr_ack <= wr_fire;
    end
  end

  // Writes only happen in IDLE and clears only in CLEAR, so the two never collide on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (state == CLEAR && cnt == 3'(i)) begin
          regs[i] <= '0;
        end else if (wr_fire && wr_sel == 3'(i) && !(ZERO_R0 && i == 0)) begin
          if (wr_be[1]) regs[i][WIDTH-1:HALF] <= wr_data[WIDTH-1:HALF];
          if (wr_be[0]) regs[i][HALF-1:0]     <= wr_data[HALF-1:0];
        end
      end
    end
  end

  assign Q0 = ZERO_R0 ? '0 : regs[0];
  assign Q1 = regs[1];
  assign Q2 = regs[2];
  assign Q3 = regs[3];
  assign Q4 = regs[4];
  assign Q5 = regs[5];
  assign Q6 = regs[6];
  assign Q7 = regs[7];

endmodule

// File: tb/tb_regbank_demux16.sv
// Directed bench for regbank_demux16: table-driven writes plus hand-written sweep/reset sequences.
module tb_regbank_demux16;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, wr_valid, wr_ready, wr_ack, clr_req, busy;
  logic [2:0]   wr_sel;
  logic [W-1:0] wr_data;
  logic [1:0]   wr_be;
  logic [W-1:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
  logic [W-1:0] qv [8];

  int total = 0;
  int bad   = 0;

  regbank_demux16 #(.WIDTH(W), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack),
    .clr_req(clr_req), .busy(busy),
    .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .Q5(Q5), .Q6(Q6), .Q7(Q7)
  );

  always #5 clk = ~clk;

  assign qv[0] = Q0;
  assign qv[1] = Q1;
  assign qv[2] = Q2;
  assign qv[3] = Q3;
  assign qv[4] = Q4;
  assign qv[5] = Q5;
  assign qv[6] = Q6;
  assign qv[7] = Q7;

  typedef struct {
    logic [2:0]   sel;
    logic [W-1:0] data;
    logic [1:0]   be;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{sel: 3'd3, data: 16'hBEEF, be: 2'b11, exp: 16'hBEEF};
    vecs[1] = '{sel: 3'd0, data: 16'h1234, be: 2'b11, exp: 16'h0000};
    vecs[2] = '{sel: 3'd5, data: 16'hBEEF, be: 2'b11, exp: 16'hBEEF};
    vecs[3] = '{sel: 3'd5, data: 16'h1234, be: 2'b01, exp: 16'hBE34};
    vecs[4] = '{sel: 3'd5, data: 16'hAA00, be: 2'b10, exp: 16'hAA34};
    vecs[5] = '{sel: 3'd5, data: 16'hFFFF, be: 2'b00, exp: 16'hAA34};
    vecs[6] = '{sel: 3'd7, data: 16'h0F0F, be: 2'b11, exp: 16'h0F0F};

    rst = 1'b1; wr_valid = 1'b1; wr_sel = 3'd4; wr_data = 16'hFFFF; wr_be = 2'b11; clr_req = 1'b1;
    tick();
    tick();
    rst = 1'b0; wr_valid = 1'b0; clr_req = 1'b0;
    for (int j = 0; j < 8; j++) chk($sformatf("rst_q%0d", j), {16'd0, qv[j]}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ack", {31'd0, wr_ack}, 32'd0);
    chk("rst_ready", {31'd0, wr_ready}, 32'd1);

    // Single writes with byte enables, one idle cycle after each.
    for (int v = 0; v < 7; v++) begin
      wr_valid = 1'b1; wr_sel = vecs[v].sel; wr_data = vecs[v].data; wr_be = vecs[v].be;
      tick();
      wr_valid = 1'b0;
      chk($sformatf("vec%0d_ack", v), {31'd0, wr_ack}, 32'd1);
      chk($sformatf("vec%0d_q", v), {16'd0, qv[vecs[v].sel]}, {16'd0, vecs[v].exp});
      tick();
      chk($sformatf("vec%0d_ack_off", v), {31'd0, wr_ack}, 32'd0);
    end
    chk("q3_kept", {16'd0, Q3}, 32'h0000BEEF);

    // Back-to-back fill of Q1..Q7: ack stays high throughout.
    wr_be = 2'b11;
    for (int j = 1; j < 8; j++) begin
      wr_valid = 1'b1; wr_sel = 3'(j); wr_data = 16'(j) * 16'h1111;
      tick();
      chk($sformatf("b2b_ack%0d", j), {31'd0, wr_ack}, 32'd1);
    end
    wr_valid = 1'b0;
    tick();
    chk("b2b_ack_off", {31'd0, wr_ack}, 32'd0);

    // Clear sweep, with a write held pending and a stray clr_req mid-sweep.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wr_valid = 1'b1; wr_sel = 3'd2; wr_data = 16'h5A5A; wr_be = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("sweep_busy_c%0d", k), {31'd0, busy}, 32'd1);
      chk($sformatf("sweep_rdy_c%0d", k), {31'd0, wr_ready}, 32'd0);
      chk($sformatf("sweep_ack_c%0d", k), {31'd0, wr_ack}, 32'd0);
      for (int j = 1; j < 8; j++)
        chk($sformatf("sweep_q%0d_c%0d", j, k), {16'd0, qv[j]},
            (j < k - 1) ? 32'd0 : {16'd0, 16'(j) * 16'h1111});
      clr_req = (k == 4);
      tick();
    end
    clr_req = 1'b0;
    chk("sweep_end_busy", {31'd0, busy}, 32'd0);
    chk("sweep_end_ready", {31'd0, wr_ready}, 32'd1);
    chk("sweep_end_ack", {31'd0, wr_ack}, 32'd0);
    for (int j = 0; j < 8; j++) chk($sformatf("sweep_end_q%0d", j), {16'd0, qv[j]}, 32'd0);
    tick();
    wr_valid = 1'b0;
    chk("pending_ack", {31'd0, wr_ack}, 32'd1);
    chk("pending_q2", {16'd0, Q2}, 32'h00005A5A);
    chk("pending_busy", {31'd0, busy}, 32'd0);

    // Write and clear on the same edge.
    wr_valid = 1'b1; wr_sel = 3'd6; wr_data = 16'hCAFE; wr_be = 2'b11; clr_req = 1'b1;
    tick();
    wr_valid = 1'b0; clr_req = 1'b0;
    chk("sim_ack", {31'd0, wr_ack}, 32'd1);
    chk("sim_q6", {16'd0, Q6}, 32'h0000CAFE);
    chk("sim_busy", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) chk("sim_ack_off", {31'd0, wr_ack}, 32'd0);
      if (k == 6) chk("sim_q6_held", {16'd0, Q6}, 32'h0000CAFE);
      if (k == 7) chk("sim_q6_clr", {16'd0, Q6}, 32'd0);
    end
    chk("sim_done_busy", {31'd0, busy}, 32'd0);

    // clr_req held high: one IDLE cycle between sweeps.
    clr_req = 1'b1;
    tick();
    chk("hold_busy0", {31'd0, busy}, 32'd1);
    repeat (7) tick();
    chk("hold_busy7", {31'd0, busy}, 32'd1);
    tick();
    chk("hold_gap_busy", {31'd0, busy}, 32'd0);
    chk("hold_gap_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    chk("hold_restart", {31'd0, busy}, 32'd1);
    clr_req = 1'b0;
    wait_idle("hold_wait_idle");

    // Reset in the middle of a sweep.
    wr_valid = 1'b1; wr_sel = 3'd3; wr_data = 16'h3333; wr_be = 2'b11;
    tick();
    wr_sel = 3'd7; wr_data = 16'h7777;
    tick();
    wr_valid = 1'b0;
    chk("pre_rst_q7", {16'd0, Q7}, 32'h00007777);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (3) tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_ready", {31'd0, wr_ready}, 32'd1);
    chk("mrst_ack", {31'd0, wr_ack}, 32'd0);
    for (int j = 0; j < 8; j++) chk($sformatf("mrst_q%0d", j), {16'd0, qv[j]}, 32'd0);
    wr_valid = 1'b1; wr_sel = 3'd4; wr_data = 16'h4444; wr_be = 2'b11;
    tick();
    wr_valid = 1'b0;
    chk("post_rst_ack", {31'd0, wr_ack}, 32'd1);
    chk("post_rst_q4", {16'd0, Q4}, 32'h00004444);
    tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regbank_demux16.md
Name: regbank_demux16

Overview:
- 1-to-8, 16-bit write-side demultiplexer with its own 8-entry register bank.
- Routes one write per cycle into the register chosen by a 3-bit select.
- Presents all eight registers in parallel on Q0..Q7, which feed the 8:1 read mux of the RiscV datapath.
- Has a sequential bulk-clear sweep and a valid/ready write handshake with a registered acknowledge.

Parameters:
- WIDTH, 16: register and data width. Must be even, because byte enables split it into two halves.
- ZERO_R0, 1: when 1, Q0 is hardwired to zero (RISC-V x0 semantics). Writes to select 0 are accepted and acked, but have no effect.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_valid  input  1  write request valid.
- wr_ready  output  1  block can accept a write this cycle.
- wr_sel  input  3  destination register index, 0..7.
- wr_data  input  WIDTH  write data.
- wr_be  input  2  byte-half enables: [1] = upper WIDTH/2 bits, [0] = lower WIDTH/2 bits.
- wr_ack  output  1  one-cycle pulse, one cycle after an accepted write.
- clr_req  input  1  request to clear all eight registers.
- busy  output  1  clear sweep in progress.
- Q0..Q7  output  WIDTH each  current register contents.

Behaviour:
- Reset, sampled at a rising edge of clk with rst=1:
  - Q0..Q7 = 0; state = IDLE; sweep counter = 0; busy = 0; wr_ack = 0.
  - rst overrides every other input in the same cycle.
  - Reset during a sweep aborts it; the block is IDLE on the next cycle.
- wr_ready is combinational and equals (state == IDLE). busy is registered and equals (state == CLEAR).
- Accepted write = wr_valid & wr_ready at a rising edge. On that edge, Q[wr_sel] takes the masked write:
  - upper half takes wr_data[WIDTH-1:WIDTH/2] if wr_be[1], otherwise it holds;
  - lower half takes wr_data[WIDTH/2-1:0] if wr_be[0], otherwise it holds.
  - The new value is visible on Q in the next cycle. Write latency is 1 cycle.
- wr_be = 00: the write is still accepted and acked, and no register changes.
- ZERO_R0 = 1: Q0 stays 0 permanently. Writes to select 0 are still acked.
- wr_ack is registered: high for exactly the cycle after each accepted write, otherwise 0.
  - Back-to-back accepted writes give a continuous wr_ack high.
- wr_valid while wr_ready = 0 is not accepted and produces no ack. The requester must hold the request; the block does not queue it.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_req = 1 at an edge. The counter is loaded with 0.
  - In CLEAR, each edge does Q[cnt] <= 0 and cnt <= cnt + 1. When cnt == 7, the transition goes back to IDLE on that same edge.
  - busy is therefore high for exactly 8 cycles.
  - Clear order is Q0 first, then Q1, and so on to Q7, one register per cycle.
  - Registers not yet reached keep their values during the sweep.
- clr_req while in CLEAR is ignored and is not queued.
- clr_req held high continuously produces back-to-back sweeps, with one IDLE cycle between them.
- wr_valid and clr_req both high in IDLE at the same edge:
  - the write is accepted (ack follows), and the sweep starts on that same edge;
  - the written register is later cleared by the sweep.
- wr_sel is a full 3-bit decode; every value is legal. There are no X outputs.

Test Plan:
- Reset then idle: assert rst for 2 cycles -> Q0..Q7 = 0x0000, busy = 0, wr_ack = 0, wr_ready = 1.
- Basic write (ZERO_R0 = 1): write sel = 3, data = 0xBEEF, be = 11 -> Q3 = 0xBEEF next cycle and wr_ack pulses for 1 cycle. Then write sel = 0, data = 0x1234 -> wr_ack pulses and Q0 stays 0x0000.
- Byte enables: Q5 = 0xBEEF, then write sel = 5, data = 0x1234, be = 01 -> Q5 = 0xBE34. Then be = 10 with data 0xAA00 -> Q5 = 0xAA34. Then be = 00 -> Q5 unchanged and wr_ack still pulses.
- Clear sweep: load Q1..Q7 = 0x1111..0x7777, then pulse clr_req -> busy high exactly 8 cycles and wr_ready low for the same 8 cycles. Q1 reads 0 after the second sweep cycle, Q7 after the eighth. A wr_valid (sel = 2) held during the sweep gives no ack until the first IDLE cycle, then is accepted.
- Simultaneous write and clear: in IDLE, wr_valid (sel = 6, data = 0xCAFE) and clr_req high together -> wr_ack pulses, Q6 = 0xCAFE briefly, and Q6 = 0 after the sweep reaches index 6.
- Reset mid-sweep: assert rst at sweep cycle 4 -> next cycle busy = 0, all Q = 0, wr_ready = 1. A new write is then accepted normally.
